// File: rtl/dadder_sched_if.sv
// dadder_sched_if: requester and dadder core handshake bundle for dadder_sched
interface dadder_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a, req_b;
   logic [DATA_WIDTH:0] rsp_sum, add_rsp_sum;
   logic [DATA_WIDTH-1:0] add_a, add_b;
   logic add_valid, add_ready, add_rsp_valid, add_rsp_ready;
   modport master (
      output req_valid, req_a, req_b, rsp_ready, add_ready, add_rsp_valid, add_rsp_sum,
      input  req_ready, rsp_valid, rsp_sum, add_valid, add_a, add_b, add_rsp_ready
   );
   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, add_ready, add_rsp_valid, add_rsp_sum,
      output req_ready, rsp_valid, rsp_sum, add_valid, add_a, add_b, add_rsp_ready
   );
endinterface

// File: rtl/dadder_sched.sv
// dadder_sched: round-robin sharing of one dadder core among NUM_REQ requesters
module dadder_sched #(
   parameter int NUM_REQ = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic cp_en,
   input  logic [NUM_REQ-1:0] cp_mask,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] cp_outstanding,
   output logic cp_err_unexp,
   dadder_sched_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t state, state_n;
   logic [IW-1:0] rr_ptr, lock_idx, gnt, sel, head_idx;
   logic [IW-1:0] fifo [MAX_OUTSTANDING];
   logic [PW-1:0] head, tail;
   logic [NUM_REQ-1:0] elig;
   logic found, act, push, pop, empty;

   assign elig = bus.req_valid & cp_mask &
                 {NUM_REQ{cp_en && (cp_outstanding < CW'(MAX_OUTSTANDING))}};

   always_comb begin
      found = 1'b0;
      gnt = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (!found && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
            found = 1'b1;
            gnt = IW'((int'(rr_ptr) + k) % NUM_REQ);
         end
   end

   // once a transfer is offered it stays locked until the core takes it
   always_comb begin
      sel = state == HOLD ? lock_idx : gnt;
      act = state == HOLD || found;
      push = act && bus.add_ready;
      state_n = act && !bus.add_ready ? HOLD : IDLE;
      bus.add_valid = act;
      bus.add_a = bus.req_a[sel*DATA_WIDTH +: DATA_WIDTH];
      bus.add_b = bus.req_b[sel*DATA_WIDTH +: DATA_WIDTH];
      bus.req_ready = push ? NUM_REQ'(1) << sel : '0;
   end

   assign empty = cp_outstanding == '0;
   assign head_idx = fifo[head];
   assign pop = bus.add_rsp_valid && bus.add_rsp_ready;

   always_comb begin
      bus.rsp_valid = empty || !bus.add_rsp_valid ? '0 : NUM_REQ'(1) << head_idx;
      bus.rsp_sum = bus.add_rsp_sum;
      bus.add_rsp_ready = !empty && bus.rsp_ready[head_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rr_ptr <= '0;
         head <= '0;
         tail <= '0;
         cp_outstanding <= '0;
         cp_err_unexp <= 1'b0;
      end else begin
         state <= state_n;
         if (push) rr_ptr <= sel == IW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         cp_outstanding <= cp_outstanding + CW'(push) - CW'(pop);
         if (bus.add_rsp_valid && empty) cp_err_unexp <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo[tail] <= sel;
      if (act) lock_idx <= sel;
   end
endmodule

// File: tb/tb_dadder_sched.sv
// tb_dadder_sched: randomized scoreboard bench for dadder_sched with directed corner cases
module tb_dadder_sched;
   localparam int N = 4;
   localparam int DW = 32;
   typedef struct {int idx; logic [DW:0] sum;} exp_t;

   logic clk = 0, reset = 1, cp_en = 0;
   logic [N-1:0] cp_mask = '0, last_acc = '0;
   logic [2:0] cp_outstanding;
   logic cp_err_unexp;
   int n_tests = 0, n_fail = 0, core_p = 100, g0;
   bit core_auto = 0;
   exp_t sb_q[$];
   logic [DW:0] core_q[$];
   int grants[$];
   logic [DW-1:0] a2, b2;

   dadder_sched_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();
   dadder_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .reset(reset), .cp_en(cp_en), .cp_mask(cp_mask),
      .cp_outstanding(cp_outstanding), .cp_err_unexp(cp_err_unexp), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (core_auto) begin
         bus.add_rsp_valid = core_q.size() != 0 && ($urandom_range(99) < core_p);
         bus.add_rsp_sum = core_q.size() != 0 ? core_q[0] : '0;
      end
   endtask

   task automatic drain();
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      bus.add_ready = 1'b1;
      core_auto = 1;
      core_p = 100;
      for (int k = 0; k < 200 && sb_q.size() != 0; k++) tick();
      tick();
      check("drain_empty", sb_q.size(), 0);
   endtask

   // scoreboard monitor: expectations come from requester operands, results from the core side
   always @(negedge clk) begin
      logic [N-1:0] acc;
      exp_t e;
      if (!reset) begin
         acc = bus.req_valid & bus.req_ready;
         check("ready_onehot", $onehot0(bus.req_ready), 1);
         check("outstanding", cp_outstanding, sb_q.size());
         for (int i = 0; i < N; i++)
            if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
               if (sb_q.size() == 0) check("rsp_unexpected", 1, 0);
               else begin
                  e = sb_q.pop_front();
                  check("rsp_idx", i, e.idx);
                  check("rsp_sum", bus.rsp_sum, e.sum);
               end
            end
         for (int i = 0; i < N; i++)
            if (acc[i]) begin
               sb_q.push_back('{i, {1'b0, bus.req_a[i*DW +: DW]} + {1'b0, bus.req_b[i*DW +: DW]}});
               grants.push_back(i);
            end
         if (bus.add_valid && bus.add_ready) core_q.push_back({1'b0, bus.add_a} + {1'b0, bus.add_b});
         if (bus.add_rsp_valid && bus.add_rsp_ready && core_q.size() != 0) void'(core_q.pop_front());
         last_acc = acc;
      end else last_acc = '0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
      bus.add_ready = 0; bus.add_rsp_valid = 0; bus.add_rsp_sum = '0;
      tick();
      tick();
      #2;
      check("rst_outstanding", cp_outstanding, 0);
      check("rst_err", cp_err_unexp, 0);
      check("rst_add_valid", bus.add_valid, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_add_rsp_ready", bus.add_rsp_ready, 0);
      reset = 0;
      // fairness: everyone requests, core always ready and answers at once
      tick();
      cp_en = 1; cp_mask = '1; bus.add_ready = 1; bus.rsp_ready = '1;
      core_auto = 1; core_p = 100;
      for (int i = 0; i < N; i++) begin
         bus.req_a[i*DW +: DW] = i;
         bus.req_b[i*DW +: DW] = 100;
      end
      bus.req_valid = '1;
      g0 = grants.size();
      for (int c = 0; c < 10; c++) tick();
      bus.req_valid = '0;
      if (grants.size() < g0 + 8) check("fair_count", grants.size() - g0, 8);
      else for (int k = 0; k < 8; k++) check("fair_order", grants[g0 + k], k % N);
      drain();
      // backpressure on requester 2 while its mask drops
      a2 = $urandom; b2 = $urandom;
      bus.req_a[2*DW +: DW] = a2; bus.req_b[2*DW +: DW] = b2;
      bus.add_ready = 0; bus.req_valid = 4'b0100;
      g0 = grants.size();
      for (int c = 0; c < 3; c++) begin
         #2;
         check("bp_add_valid", bus.add_valid, 1);
         check("bp_add_a", bus.add_a, a2);
         check("bp_add_b", bus.add_b, b2);
         check("bp_req_ready", bus.req_ready, 0);
         tick();
         if (c == 0) begin cp_mask[2] = 0; bus.req_valid[0] = 1; end
      end
      bus.add_ready = 1;
      #2;
      check("bp_accept_ready", bus.req_ready, 4'b0100);
      check("bp_accept_a", bus.add_a, a2);
      tick();
      bus.req_valid = '0; cp_mask = '1;
      check("bp_push_count", grants.size() - g0, 1);
      check("bp_push_idx", grants[grants.size() - 1], 2);
      drain();
      // FIFO full with a silent core, then one pop
      core_auto = 0; bus.add_rsp_valid = 0;
      bus.req_valid = '1; g0 = grants.size();
      for (int c = 0; c < 4; c++) tick();
      #2;
      check("full_outstanding", cp_outstanding, 4);
      check("full_add_valid", bus.add_valid, 0);
      check("full_grants", grants.size() - g0, 4);
      bus.add_rsp_valid = 1; bus.add_rsp_sum = core_q[0];
      #1;
      check("full_no_bypass", bus.add_valid, 0);
      check("full_pop_ready", bus.add_rsp_ready, 1);
      tick();
      bus.add_rsp_valid = 0;
      #2;
      check("full_after_pop", cp_outstanding, 3);
      check("full_regrant", bus.add_valid, 1);
      tick();
      bus.req_valid = '0;
      drain();
      // 33-bit overflow sum routed to requester 1 only
      core_auto = 0; bus.add_rsp_valid = 0;
      bus.req_a[DW +: DW] = 32'hFFFF_FFFF; bus.req_b[DW +: DW] = 32'h1;
      bus.req_valid = 4'b0010;
      tick();
      bus.req_valid = '0;
      bus.add_rsp_valid = 1; bus.add_rsp_sum = 33'h1_0000_0000;
      #2;
      check("ovf_rsp_valid", bus.rsp_valid, 4'b0010);
      check("ovf_rsp_sum", bus.rsp_sum, 33'h1_0000_0000);
      tick();
      bus.add_rsp_valid = 0;
      // unexpected result with an empty FIFO
      tick();
      bus.add_rsp_valid = 1; bus.add_rsp_sum = 33'h5;
      #2;
      check("unexp_ready", bus.add_rsp_ready, 0);
      check("unexp_rsp_valid", bus.rsp_valid, 0);
      check("unexp_err_before", cp_err_unexp, 0);
      tick();
      bus.add_rsp_valid = 0;
      #2;
      check("unexp_err_set", cp_err_unexp, 1);
      tick();
      #2;
      check("unexp_err_held", cp_err_unexp, 1);
      // reset while holding with two entries outstanding
      bus.req_valid = 4'b0011;
      tick();
      tick();
      bus.req_valid = 4'b0100; bus.add_ready = 0;
      #2;
      check("hold_outstanding", cp_outstanding, 2);
      tick();
      #2;
      check("hold_add_valid", bus.add_valid, 1);
      reset = 1; bus.req_valid = '0;
      tick();
      reset = 0;
      core_q.delete(); sb_q.delete();
      #2;
      check("rst2_add_valid", bus.add_valid, 0);
      check("rst2_outstanding", cp_outstanding, 0);
      check("rst2_err", cp_err_unexp, 0);
      bus.req_valid = '1; bus.add_ready = 1;
      #1;
      check("rst2_rr_ptr", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = '0;
      drain();
      // random traffic under the requester hold-until-accepted protocol
      core_p = 60;
      for (int c = 0; c < 500; c++) begin
         tick();
         cp_en = $urandom_range(99) < 90;
         cp_mask = N'($urandom | $urandom);
         bus.add_ready = $urandom_range(99) < 70;
         bus.rsp_ready = N'($urandom);
         for (int i = 0; i < N; i++)
            if (!bus.req_valid[i] || last_acc[i]) begin
               bus.req_valid[i] = 1'($urandom_range(1));
               bus.req_a[i*DW +: DW] = $urandom;
               bus.req_b[i*DW +: DW] = $urandom;
            end
      end
      drain();
      check("final_err", cp_err_unexp, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
